// File: rtl/conv_window_gen_pkg.sv
// ---------------------------------------------------------------------------
// conv_window_gen_pkg
// Shared types and constants for the convolution window generator.
//   PIX_W          : pixel width (8-bit unsigned)
//   DEF_K_H/DEF_K_W: default kernel height/width
//   pix_t, win_t   : pixel and default-size window types
//                    (win[0][0] = oldest row, leftmost column)
//   state_t        : frame-control FSM states
//   last_origin()  : largest multiple of 'step' that is <= 'span'
//   cnt_w()        : counter width for a 0..n-1 counter (at least 1 bit)
// ---------------------------------------------------------------------------
package conv_window_gen_pkg;

  localparam int PIX_W   = 8;
  localparam int DEF_K_H = 3;
  localparam int DEF_K_W = 3;

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t [DEF_K_H-1:0][DEF_K_W-1:0] win_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int last_origin(input int span, input int step);
    return span - (span % step);
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// ---------------------------------------------------------------------------
// conv_window_gen_if
// Pixel-in / window-out handshake bundle of the window generator.
//   pix_valid/pix_ready/pix_data : raster-scan pixel stream into the generator
//   win/win_valid/win_ready      : K_H x K_W window out to the conv unit
//   win_last                     : marks the final window of a frame
// Modports:
//   master : the window generator (consumes pixels, produces windows)
//   slave  : the environment around it (pixel source + window sink)
// ---------------------------------------------------------------------------
interface conv_window_gen_if #(
  parameter int K_H = conv_window_gen_pkg::DEF_K_H,
  parameter int K_W = conv_window_gen_pkg::DEF_K_W
);
  import conv_window_gen_pkg::*;

  logic                        pix_valid;
  logic                        pix_ready;
  pix_t                        pix_data;
  pix_t [K_H-1:0][K_W-1:0]     win;
  logic                        win_valid;
  logic                        win_ready;
  logic                        win_last;

  modport master (
    input  pix_valid, pix_data, win_ready,
    output pix_ready, win, win_valid, win_last
  );

  modport slave (
    output pix_valid, pix_data, win_ready,
    input  pix_ready, win, win_valid, win_last
  );

endinterface

// File: rtl/conv_window_gen_line_buf.sv
// ---------------------------------------------------------------------------
// conv_line_buf
// One image row of pixel delay: a DEPTH-stage shift register advanced only
// when en is high. With DEPTH = image width and en = "pixel accepted", dout
// is the pixel from the same column one row earlier.
// Ports:
//   clk  : clock
//   en   : shift enable (one accepted pixel)
//   din  : pixel entering the row
//   dout : pixel leaving the row (DEPTH accepted pixels ago)
// ---------------------------------------------------------------------------
module conv_line_buf
  import conv_window_gen_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic en,
  input  pix_t din,
  output pix_t dout
);

  pix_t mem [DEPTH];

  // NOTE: the delay storage has no reset; its contents are always
  // overwritten by the current frame before any window uses them, and
  // leaving it unreset lets it map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// ---------------------------------------------------------------------------
// conv_window_gen
// Producer side of the conv unit's window interface. Accepts a raster-scan
// 8-bit pixel stream, keeps K_H-1 line buffers plus a K_H x K_W shift
// window, and emits every valid-convolution window (no padding, stride 1)
// with a valid/ready handshake. Backpressure on the window side stalls the
// pixel side, so no window is dropped; an accepted pixel and an accepted
// window in the same cycle give full throughput.
//
// Build option:
//   CONV_WIN_STRIDE2_EN : emit only windows whose top-left origin has both
//                         coordinates even; win_last moves to the last such
//                         window.
//
// Parameters: IMG_W, IMG_H (image size), K_H, K_W (window size, K_H >= 2)
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   start  : one-cycle pulse, begins a frame when idle
//   busy   : high while a frame is in RUN or DRAIN
//   done   : one-cycle pulse after the last window is accepted
//   wif    : pixel/window handshake bundle (master side)
// ---------------------------------------------------------------------------
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int K_H   = DEF_K_H,
  parameter int K_W   = DEF_K_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  conv_window_gen_if.master        wif
);

  localparam int ROW_W = cnt_w(IMG_H);
  localparam int COL_W = cnt_w(IMG_W);

  localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K_W - 1);

`ifdef CONV_WIN_STRIDE2_EN
  // Bottom-right pixel of the last window whose origin is even in both axes.
  localparam int LAST_R = last_origin(IMG_H - K_H, 2) + K_H - 1;
  localparam int LAST_C = last_origin(IMG_W - K_W, 2) + K_W - 1;
  // Origin row r-(K_H-1) is even when r has the same parity as K_H-1.
  localparam logic ROW_PAR = 1'((K_H - 1) % 2);
  localparam logic COL_PAR = 1'((K_W - 1) % 2);
`else
  localparam int LAST_R = IMG_H - 1;
  localparam int LAST_C = IMG_W - 1;
`endif

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LAST_R);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LAST_C);

  state_t                   state, state_nxt;
  logic [ROW_W-1:0]         row;
  logic [COL_W-1:0]         col;
  pix_t [K_H-1:0][K_W-1:0]  win_q;
  logic                     win_valid_q;
  logic                     win_last_q;
  logic                     last_seen;   // final window already handed off

  logic                     pix_ready;
  logic                     pix_acc;
  logic                     win_acc;
  logic                     emit;
  logic                     at_frame_end;
  logic                     at_last_win;

  // chain[0] is the incoming pixel (row r); chain[k+1] is row r-1-k.
  pix_t                     chain [K_H];

  assign pix_acc      = wif.pix_valid && pix_ready;
  assign win_acc      = win_valid_q && wif.win_ready;
  assign at_frame_end = (row == ROW_MAX) && (col == COL_MAX);
  assign at_last_win  = (row == ROW_LAST) && (col == COL_LAST);

`ifdef CONV_WIN_STRIDE2_EN
  assign emit = (row >= ROW_FIRST) && (col >= COL_FIRST) &&
                (row[0] == ROW_PAR) && (col[0] == COL_PAR);
`else
  // Windows with c < K_W-1 straddle a row wrap and are never emitted.
  assign emit = (row >= ROW_FIRST) && (col >= COL_FIRST);
`endif

  // -------------------------------------------------------------------------
  // Line buffer chain: each stage delays its input by one full row.
  // -------------------------------------------------------------------------
  assign chain[0] = wif.pix_data;

  for (genvar k = 0; k < K_H - 1; k++) begin : g_lb
    conv_line_buf #(
      .DEPTH (IMG_W)
    ) u_lb (
      .clk  (clk),
      .en   (pix_acc),
      .din  (chain[k]),
      .dout (chain[k+1])
    );
  end

  // -------------------------------------------------------------------------
  // Frame-control FSM
  // -------------------------------------------------------------------------
  // NOTE: state and every other register below use non-blocking
  // assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy      = 1'b1;
        // A pixel may enter only if the window it might create has room.
        pix_ready = !win_valid_q || wif.win_ready;
        if (pix_acc && at_frame_end) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // With strided emission the final window can leave before the
        // frame's last pixel arrives, hence the sticky last_seen.
        if ((win_acc && win_last_q) || last_seen) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Raster counters, shift window and output handshake
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row         <= '0;
      col         <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      last_seen   <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        row       <= '0;
        col       <= '0;
        last_seen <= 1'b0;
      end

      if (pix_acc) begin
        if (col == COL_MAX) begin
          col <= '0;
          row <= (row == ROW_MAX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end

        // Shift columns left; the new right column is the vertical slice
        // at this column, oldest row at index 0.
        for (int i = 0; i < K_H; i++) begin
          for (int j = 0; j < K_W - 1; j++) begin
            win_q[i][j] <= win_q[i][j+1];
          end
          win_q[i][K_W-1] <= chain[K_H-1-i];
        end
      end

      // A new window overrides the clear so back-to-back windows have no
      // bubble; otherwise an accepted window retires.
      if (pix_acc && emit) begin
        win_valid_q <= 1'b1;
        win_last_q  <= at_last_win;
      end else if (wif.win_ready) begin
        win_valid_q <= 1'b0;
        win_last_q  <= 1'b0;
      end

      if (win_acc && win_last_q) last_seen <= 1'b1;
    end
  end

  assign wif.pix_ready = pix_ready;
  assign wif.win       = win_q;
  assign wif.win_valid = win_valid_q;
  assign wif.win_last  = win_last_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// ---------------------------------------------------------------------------
// tb_conv_window_gen
// Drives a 4x4 and an 8x8 instance of conv_window_gen. A golden model builds
// the expected window sequence straight from the image and queues it; every
// window handshake pops and compares window, win_last and the all-ones
// weight sum. Honors CONV_WIN_STRIDE2_EN for the expected window set.
// ---------------------------------------------------------------------------
module tb_conv_window_gen;
  import conv_window_gen_pkg::*;

  localparam int KH = DEF_K_H;
  localparam int KW = DEF_K_W;
`ifdef CONV_WIN_STRIDE2_EN
  localparam int STEP = 2;
  localparam int EXP4 = 1;
  localparam int EXP8 = 9;
`else
  localparam int STEP = 1;
  localparam int EXP4 = 4;
  localparam int EXP8 = 36;
`endif

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic sel       = 1'b0;   // 0: 4x4 instance, 1: 8x8 instance
  logic start     = 1'b0;
  logic pix_valid = 1'b0;
  logic win_ready = 1'b0;
  pix_t pix_data  = '0;

  logic start4, start8, busy4, busy8, done4, done8;

  conv_window_gen_if #(.K_H(KH), .K_W(KW)) if4 ();
  conv_window_gen_if #(.K_H(KH), .K_W(KW)) if8 ();

  assign start4        = !sel && start;
  assign start8        =  sel && start;
  assign if4.pix_valid = !sel && pix_valid;
  assign if8.pix_valid =  sel && pix_valid;
  assign if4.pix_data  = pix_data;
  assign if8.pix_data  = pix_data;
  assign if4.win_ready = win_ready;
  assign if8.win_ready = win_ready;

  conv_window_gen #(.IMG_W(4), .IMG_H(4), .K_H(KH), .K_W(KW)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .busy  (busy4),
    .done  (done4),
    .wif   (if4.master)
  );

  conv_window_gen #(.IMG_W(8), .IMG_H(8), .K_H(KH), .K_W(KW)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .busy  (busy8),
    .done  (done8),
    .wif   (if8.master)
  );

  logic o_pix_ready, o_win_valid, o_win_last, o_busy, o_done;
  win_t o_win;
  assign o_pix_ready = sel ? if8.pix_ready : if4.pix_ready;
  assign o_win_valid = sel ? if8.win_valid : if4.win_valid;
  assign o_win_last  = sel ? if8.win_last  : if4.win_last;
  assign o_win       = sel ? if8.win       : if4.win;
  assign o_busy      = sel ? busy8 : busy4;
  assign o_done      = sel ? done8 : done4;

  always #5 clk = ~clk;

  typedef struct {
    win_t w;
    logic last;
    int   sum;
  } exp_t;

  exp_t exp_q[$];
  pix_t img [8][8];
  int   n_total = 0;
  int   n_bad   = 0;

  function automatic int win_sum(input win_t x);
    int s = 0;
    for (int i = 0; i < KH; i++)
      for (int j = 0; j < KW; j++)
        s += int'(x[i][j]);
    return s;
  endfunction

  task automatic fill_image(input int h, input int w, input bit ramp);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        img[r][c] = ramp ? pix_t'(r * w + c) : pix_t'($urandom);
  endtask

  // Golden model: every window by its bottom-right pixel, in raster order.
  task automatic build_expected(input int h, input int w);
    exp_t e;
    exp_q.delete();
    for (int r = KH - 1; r < h; r++) begin
      for (int c = KW - 1; c < w; c++) begin
        if (((r - KH + 1) % STEP == 0) && ((c - KW + 1) % STEP == 0)) begin
          for (int i = 0; i < KH; i++)
            for (int j = 0; j < KW; j++)
              e.w[i][j] = img[r - KH + 1 + i][c - KW + 1 + j];
          e.last = 1'b0;
          e.sum  = win_sum(e.w);
          exp_q.push_back(e);
        end
      end
    end
    if (exp_q.size() > 0) exp_q[exp_q.size() - 1].last = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs one full frame on the selected instance and scores every window.
  task automatic run_frame(input bit s, input int h, input int w,
                           input bit gaps, input bit toggle,
                           input bit poke_start, input int exp_count,
                           input string tag);
    int   idx = 0, got = 0, cyc = 0, cyc_last = -10;
    bit   acc = 0, prev_stall = 0, fin = 0;
    win_t prev_win = '0;
    exp_t e;
    sel = s;
    build_expected(h, w);
    win_ready = 1'b1;
    pix_valid = 1'b0;
    pulse_start();
    while (!fin && cyc < 3000) begin
      pix_valid = (idx < h * w) && (!gaps || $urandom_range(0, 3) != 0);
      pix_data  = (idx < h * w) ? img[idx / w][idx % w] : pix_t'($urandom);
      win_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      start     = poke_start && (cyc == 7);
      @(negedge clk);
      if (cyc == 0) begin
        n_total++;
        if (o_busy !== 1'b1) begin
          n_bad++;
          $display("FAIL %s busy_in_run: got %b exp 1", tag, o_busy);
        end
      end
      if (prev_stall) begin
        n_total++;
        if (o_win_valid !== 1'b1 || o_win !== prev_win) begin
          n_bad++;
          $display("FAIL %s stall_hold: got v=%b %h exp v=1 %h", tag, o_win_valid, o_win, prev_win);
        end
      end
      if (o_win_valid && !win_ready) begin
        n_total++;
        if (o_pix_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL %s stall_pix_ready: got %b exp 0", tag, o_pix_ready);
        end
      end
      if (o_win_valid && win_ready) begin
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL %s extra_window: got %h exp none", tag, o_win);
        end else begin
          e = exp_q.pop_front();
          if (o_win !== e.w || o_win_last !== e.last || win_sum(o_win) != e.sum) begin
            n_bad++;
            $display("FAIL %s window%0d: got %h last=%b sum=%0d exp %h last=%b sum=%0d",
                     tag, got, o_win, o_win_last, win_sum(o_win), e.w, e.last, e.sum);
          end
        end
        if (o_win_last) cyc_last = cyc;
        got++;
      end
      if (o_done) begin
        n_total++;
        if (got != exp_count || exp_q.size() != 0 || cyc != cyc_last + 1) begin
          n_bad++;
          $display("FAIL %s done: got windows=%0d left=%0d done_delay=%0d exp windows=%0d left=0 done_delay=1",
                   tag, got, exp_q.size(), cyc - cyc_last, exp_count);
        end
        fin = 1;
      end
      prev_stall = o_win_valid && !win_ready;
      prev_win   = o_win;
      acc        = pix_valid && o_pix_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    start     = 1'b0;
    pix_valid = 1'b0;
    n_total++;
    if (!fin) begin
      n_bad++;
      $display("FAIL %s timeout: got windows=%0d exp %0d with done", tag, got, exp_count);
    end
    @(negedge clk);
    n_total++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_pulse: got done=%b busy=%b exp 0 0", tag, o_done, o_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({if4.pix_ready, if4.win_valid, if4.win_last, busy4, done4} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl4: got %b exp 00000",
               {if4.pix_ready, if4.win_valid, if4.win_last, busy4, done4});
    end
    n_total++;
    if ({if8.pix_ready, if8.win_valid, if8.win_last, busy8, done8} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl8: got %b exp 00000",
               {if8.pix_ready, if8.win_valid, if8.win_last, busy8, done8});
    end
    n_total++;
    if (if4.win !== '0 || if8.win !== '0) begin
      n_bad++;
      $display("FAIL reset_win: got %h %h exp 0", if4.win, if8.win);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    fill_image(4, 4, 1'b1);
    run_frame(1'b0, 4, 4, 1'b0, 1'b0, 1'b0, EXP4, "basic4x4");
  endtask

  task automatic test_backpressure();
    fill_image(4, 4, 1'b1);
    run_frame(1'b0, 4, 4, 1'b0, 1'b1, 1'b0, EXP4, "bp4x4");
  endtask

  task automatic test_random_gaps();
    fill_image(8, 8, 1'b0);
    run_frame(1'b1, 8, 8, 1'b1, 1'b0, 1'b0, EXP8, "gaps8x8");
  endtask

  task automatic test_mid_reset();
    int n_acc = 0, cyc = 0;
    sel = 1'b1;
    fill_image(8, 8, 1'b0);
    win_ready = 1'b1;
    pulse_start();
    while (n_acc < 20 && cyc < 200) begin
      pix_valid = 1'b1;
      pix_data  = img[n_acc / 8][n_acc % 8];
      @(negedge clk);
      if (pix_valid && o_pix_ready) n_acc++;
      @(posedge clk); #1;
      cyc++;
    end
    n_total++;
    if (n_acc != 20) begin
      n_bad++;
      $display("FAIL midreset_feed: got %0d pixels exp 20", n_acc);
    end
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({o_pix_ready, o_win_valid, o_win_last, o_busy, o_done} !== 5'b0) begin
      n_bad++;
      $display("FAIL midreset_ctrl: got %b exp 00000",
               {o_pix_ready, o_win_valid, o_win_last, o_busy, o_done});
    end
    n_total++;
    if (o_win !== '0) begin
      n_bad++;
      $display("FAIL midreset_win: got %h exp 0", o_win);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill_image(8, 8, 1'b0);
    run_frame(1'b1, 8, 8, 1'b0, 1'b0, 1'b0, EXP8, "after_reset8x8");
  endtask

  task automatic test_start_ignored();
    sel = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      pix_valid = 1'b1;
      pix_data  = pix_t'($urandom);
      @(negedge clk);
      n_total++;
      if (o_pix_ready !== 1'b0 || o_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_pixel: got ready=%b busy=%b exp 0 0", o_pix_ready, o_busy);
      end
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    fill_image(8, 8, 1'b0);
    run_frame(1'b1, 8, 8, 1'b1, 1'b0, 1'b1, EXP8, "start_poke8x8");
  endtask

  task automatic test_back_to_back();
    fill_image(8, 8, 1'b0);
    run_frame(1'b1, 8, 8, 1'b1, 1'b1, 1'b0, EXP8, "b2b_a");
    fill_image(8, 8, 1'b0);
    run_frame(1'b1, 8, 8, 1'b0, 1'b1, 1'b0, EXP8, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random_gaps();
    test_mid_reset();
    test_start_ignored();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
